// File: rtl/buspirate_pkg.sv
// Shared constants for the Bus Pirate FPGA slice: register map, ID value,
// pin indices and bus width defaults.
package buspirate_pkg;

   localparam int unsigned DataWidthDefault = 16;
   localparam int unsigned AddWidthDefault  = 6;
   localparam int unsigned NumPins          = 5;
   localparam int unsigned LatWidth         = 9;

   localparam logic [15:0] IdValue = 16'hB9A1;

   localparam int unsigned AddrId      = 0;
   localparam int unsigned AddrDir     = 1;
   localparam int unsigned AddrOd      = 2;
   localparam int unsigned AddrOut     = 3;
   localparam int unsigned AddrIn      = 4;
   localparam int unsigned AddrLat     = 5;
   localparam int unsigned AddrIrqEn   = 6;
   localparam int unsigned AddrIrqStat = 7;
   localparam int unsigned AddrSwIrq   = 8;

   localparam int unsigned PinMosi  = 0;
   localparam int unsigned PinClock = 1;
   localparam int unsigned PinMiso  = 2;
   localparam int unsigned PinCs    = 3;
   localparam int unsigned PinAux   = 4;

endpackage

// File: rtl/iobuf_ctrl.sv
// Per-pin 74LVC buffer control: push-pull / open-drain drive selection and a
// 2-flop synchronizer on the FPGA-side buffer data.
module iobuf_ctrl (
   input  logic clock,
   input  logic rst_n,
   input  logic dir,
   input  logic od,
   input  logic out_val,
   output logic bufdir,
   output logic bufod,
   output logic in_sync,
   inout  wire  bufio
);

   logic drive_en;
   logic drive_val;
   logic meta_q;
   logic sync_q;

   always_comb begin
      bufdir    = dir;
      drive_en  = dir;
      drive_val = out_val;
      // Open-drain only ever pulls low; a released line leaves the buffer off.
      if (od) begin
         bufdir    = dir & ~out_val;
         drive_en  = dir & ~out_val;
         drive_val = 1'b0;
      end
   end

   assign bufod = od;
   assign bufio = drive_en ? drive_val : 1'bz;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= bufio;
         sync_q <= meta_q;
      end
   end

   assign in_sync = sync_q;

endmodule

// File: rtl/buspirate_top.sv
// Bus Pirate FPGA top: MCU async register bus, five buffered I/O pins,
// latch output, interrupts and an idle SRAM interface.
module buspirate_top
   import buspirate_pkg::*;
#(
   parameter int unsigned MC_DATA_WIDTH = DataWidthDefault,
   parameter int unsigned MC_ADD_WIDTH  = AddWidthDefault
) (
   input  logic                     clock,
   input  logic                     rst_n,
   output logic                     bufdir_mosi,
   output logic                     bufdir_clock,
   output logic                     bufdir_miso,
   output logic                     bufdir_cs,
   output logic                     bufdir_aux,
   output logic                     bufod_mosi,
   output logic                     bufod_clock,
   output logic                     bufod_miso,
   output logic                     bufod_cs,
   output logic                     bufod_aux,
   inout  wire                      bufio_mosi,
   inout  wire                      bufio_clock,
   inout  wire                      bufio_miso,
   inout  wire                      bufio_cs,
   inout  wire                      bufio_aux,
   output logic                     lat_oe,
   output logic [7:0]               lat,
   input  logic                     mc_oe,
   input  logic                     mc_ce,
   input  logic                     mc_we,
   input  logic [MC_ADD_WIDTH-1:0]  mc_add,
   inout  wire  [MC_DATA_WIDTH-1:0] mc_data,
   output logic                     irq0,
   output logic                     irq1,
   output logic                     sram_clock,
   output logic                     sram0_cs,
   output logic                     sram1_cs,
   inout  wire  [3:0]               sram0_sio,
   inout  wire  [3:0]               sram1_sio
);

   logic [1:0]               ce_sync_q;
   logic [1:0]               we_sync_q;
   logic                     we_prev_q;
   logic                     ce_s;
   logic                     we_s;
   logic                     commit;
   logic [MC_ADD_WIDTH-1:0]  cap_add_q;
   logic [MC_DATA_WIDTH-1:0] cap_data_q;
   logic                     cap_valid_q;

   logic [NumPins-1:0]  dir_q, dir_d;
   logic [NumPins-1:0]  od_q, od_d;
   logic [NumPins-1:0]  out_q, out_d;
   logic [NumPins-1:0]  irqen_q, irqen_d;
   logic [NumPins-1:0]  irqstat_q, irqstat_d;
   logic [NumPins-1:0]  w1c;
   logic [NumPins-1:0]  pin_in;
   logic [NumPins-1:0]  in_prev_q;
   logic [LatWidth-1:0] lat_q, lat_d;
   logic                swirq_q, swirq_d;
   logic                irq0_q;
   logic [MC_DATA_WIDTH-1:0] rdata;
   logic                unused_cap_bits;
   logic                unused_sram;

   assign ce_s   = ce_sync_q[1];
   assign we_s   = we_sync_q[1];
   assign commit = we_s & ~we_prev_q & cap_valid_q;

   // Strobe synchronizers idle high so reset release never looks like a we edge.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         ce_sync_q   <= 2'b11;
         we_sync_q   <= 2'b11;
         we_prev_q   <= 1'b1;
         cap_add_q   <= '0;
         cap_data_q  <= '0;
         cap_valid_q <= 1'b0;
      end else begin
         ce_sync_q <= {ce_sync_q[0], mc_ce};
         we_sync_q <= {we_sync_q[0], mc_we};
         we_prev_q <= we_s;
         if (!ce_s && !we_s) begin
            cap_add_q   <= mc_add;
            cap_data_q  <= mc_data;
            cap_valid_q <= 1'b1;
         end else if (commit) begin
            cap_valid_q <= 1'b0;
         end
      end
   end

   always_comb begin
      dir_d   = dir_q;
      od_d    = od_q;
      out_d   = out_q;
      irqen_d = irqen_q;
      lat_d   = lat_q;
      swirq_d = swirq_q;
      w1c     = '0;
      if (commit) begin
         case (cap_add_q)
            MC_ADD_WIDTH'(AddrDir):     dir_d   = cap_data_q[NumPins-1:0];
            MC_ADD_WIDTH'(AddrOd):      od_d    = cap_data_q[NumPins-1:0];
            MC_ADD_WIDTH'(AddrOut):     out_d   = cap_data_q[NumPins-1:0];
            MC_ADD_WIDTH'(AddrLat):     lat_d   = cap_data_q[LatWidth-1:0];
            MC_ADD_WIDTH'(AddrIrqEn):   irqen_d = cap_data_q[NumPins-1:0];
            MC_ADD_WIDTH'(AddrIrqStat): w1c     = cap_data_q[NumPins-1:0];
            MC_ADD_WIDTH'(AddrSwIrq):   swirq_d = cap_data_q[0];
            default: ;
         endcase
      end
      // A fresh input change outranks a simultaneous clear.
      irqstat_d = (irqstat_q & ~w1c) | (pin_in ^ in_prev_q);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         dir_q     <= '0;
         od_q      <= '0;
         out_q     <= '0;
         irqen_q   <= '0;
         irqstat_q <= '0;
         in_prev_q <= '0;
         lat_q     <= '0;
         swirq_q   <= 1'b0;
         irq0_q    <= 1'b0;
      end else begin
         dir_q     <= dir_d;
         od_q      <= od_d;
         out_q     <= out_d;
         irqen_q   <= irqen_d;
         irqstat_q <= irqstat_d;
         in_prev_q <= pin_in;
         lat_q     <= lat_d;
         swirq_q   <= swirq_d;
         irq0_q    <= |(irqstat_q & irqen_q);
      end
   end

   always_comb begin
      rdata = '0;
      case (mc_add)
         MC_ADD_WIDTH'(AddrId):      rdata = MC_DATA_WIDTH'(IdValue);
         MC_ADD_WIDTH'(AddrDir):     rdata = MC_DATA_WIDTH'(dir_q);
         MC_ADD_WIDTH'(AddrOd):      rdata = MC_DATA_WIDTH'(od_q);
         MC_ADD_WIDTH'(AddrOut):     rdata = MC_DATA_WIDTH'(out_q);
         MC_ADD_WIDTH'(AddrIn):      rdata = MC_DATA_WIDTH'(pin_in);
         MC_ADD_WIDTH'(AddrLat):     rdata = MC_DATA_WIDTH'(lat_q);
         MC_ADD_WIDTH'(AddrIrqEn):   rdata = MC_DATA_WIDTH'(irqen_q);
         MC_ADD_WIDTH'(AddrIrqStat): rdata = MC_DATA_WIDTH'(irqstat_q);
         MC_ADD_WIDTH'(AddrSwIrq):   rdata = MC_DATA_WIDTH'(swirq_q);
         default: ;
      endcase
   end

   assign mc_data = (!mc_ce && !mc_oe && mc_we) ? rdata : {MC_DATA_WIDTH{1'bz}};

   iobuf_ctrl u_pin_mosi (
      .clock   (clock),
      .rst_n   (rst_n),
      .dir     (dir_q[PinMosi]),
      .od      (od_q[PinMosi]),
      .out_val (out_q[PinMosi]),
      .bufdir  (bufdir_mosi),
      .bufod   (bufod_mosi),
      .in_sync (pin_in[PinMosi]),
      .bufio   (bufio_mosi)
   );

   iobuf_ctrl u_pin_clock (
      .clock   (clock),
      .rst_n   (rst_n),
      .dir     (dir_q[PinClock]),
      .od      (od_q[PinClock]),
      .out_val (out_q[PinClock]),
      .bufdir  (bufdir_clock),
      .bufod   (bufod_clock),
      .in_sync (pin_in[PinClock]),
      .bufio   (bufio_clock)
   );

   iobuf_ctrl u_pin_miso (
      .clock   (clock),
      .rst_n   (rst_n),
      .dir     (dir_q[PinMiso]),
      .od      (od_q[PinMiso]),
      .out_val (out_q[PinMiso]),
      .bufdir  (bufdir_miso),
      .bufod   (bufod_miso),
      .in_sync (pin_in[PinMiso]),
      .bufio   (bufio_miso)
   );

   iobuf_ctrl u_pin_cs (
      .clock   (clock),
      .rst_n   (rst_n),
      .dir     (dir_q[PinCs]),
      .od      (od_q[PinCs]),
      .out_val (out_q[PinCs]),
      .bufdir  (bufdir_cs),
      .bufod   (bufod_cs),
      .in_sync (pin_in[PinCs]),
      .bufio   (bufio_cs)
   );

   iobuf_ctrl u_pin_aux (
      .clock   (clock),
      .rst_n   (rst_n),
      .dir     (dir_q[PinAux]),
      .od      (od_q[PinAux]),
      .out_val (out_q[PinAux]),
      .bufdir  (bufdir_aux),
      .bufod   (bufod_aux),
      .in_sync (pin_in[PinAux]),
      .bufio   (bufio_aux)
   );

   assign lat    = lat_q[7:0];
   assign lat_oe = lat_q[8];
   assign irq0   = irq0_q;
   assign irq1   = swirq_q;

   assign sram_clock = 1'b0;
   assign sram0_cs   = 1'b1;
   assign sram1_cs   = 1'b1;
   assign sram0_sio  = 4'bz;
   assign sram1_sio  = 4'bz;

   assign unused_cap_bits = ^cap_data_q[MC_DATA_WIDTH-1:LatWidth];
   assign unused_sram     = ^{sram0_sio, sram1_sio};

endmodule

// File: tb/tb_buspirate_top.sv
// Directed self-checking bench for buspirate_top: register access, pin drive
// modes, input interrupts, latch/soft-irq outputs and reset behaviour.
module tb_buspirate_top;

   logic        clock;
   logic        rst_n;
   logic        mc_oe, mc_ce, mc_we;
   logic [5:0]  mc_add;
   logic [15:0] tb_data;
   logic        tb_data_en;
   logic        tb_miso_en, tb_miso_val;
   logic        tb_aux_en, tb_aux_val;

   wire         bufio_mosi, bufio_clock, bufio_miso, bufio_cs, bufio_aux;
   wire  [15:0] mc_data;
   wire  [3:0]  sram0_sio, sram1_sio;
   logic        bufdir_mosi, bufdir_clock, bufdir_miso, bufdir_cs, bufdir_aux;
   logic        bufod_mosi, bufod_clock, bufod_miso, bufod_cs, bufod_aux;
   logic        lat_oe;
   logic [7:0]  lat;
   logic        irq0, irq1;
   logic        sram_clock, sram0_cs, sram1_cs;

   int pass_cnt;
   int total_cnt;

   assign mc_data    = tb_data_en ? tb_data : 16'bz;
   assign bufio_miso = tb_miso_en ? tb_miso_val : 1'bz;
   assign bufio_aux  = tb_aux_en ? tb_aux_val : 1'bz;

   buspirate_top dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .bufdir_mosi  (bufdir_mosi),
      .bufdir_clock (bufdir_clock),
      .bufdir_miso  (bufdir_miso),
      .bufdir_cs    (bufdir_cs),
      .bufdir_aux   (bufdir_aux),
      .bufod_mosi   (bufod_mosi),
      .bufod_clock  (bufod_clock),
      .bufod_miso   (bufod_miso),
      .bufod_cs     (bufod_cs),
      .bufod_aux    (bufod_aux),
      .bufio_mosi   (bufio_mosi),
      .bufio_clock  (bufio_clock),
      .bufio_miso   (bufio_miso),
      .bufio_cs     (bufio_cs),
      .bufio_aux    (bufio_aux),
      .lat_oe       (lat_oe),
      .lat          (lat),
      .mc_oe        (mc_oe),
      .mc_ce        (mc_ce),
      .mc_we        (mc_we),
      .mc_add       (mc_add),
      .mc_data      (mc_data),
      .irq0         (irq0),
      .irq1         (irq1),
      .sram_clock   (sram_clock),
      .sram0_cs     (sram0_cs),
      .sram1_cs     (sram1_cs),
      .sram0_sio    (sram0_sio),
      .sram1_sio    (sram1_sio)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Write cycle; the register is committed within 4 clocks of mc_we rising.
   task automatic bus_write(input logic [5:0] addr, input logic [15:0] data);
      @(negedge clock);
      mc_add     = addr;
      tb_data    = data;
      tb_data_en = 1'b1;
      mc_ce      = 1'b0;
      mc_we      = 1'b0;
      repeat (4) @(negedge clock);
      mc_we = 1'b1;
      mc_ce = 1'b1;
      repeat (4) @(negedge clock);
      tb_data_en = 1'b0;
   endtask

   task automatic bus_read(input logic [5:0] addr, output logic [15:0] data);
      @(negedge clock);
      mc_add = addr;
      mc_ce  = 1'b0;
      mc_oe  = 1'b0;
      #2;
      data  = mc_data;
      mc_ce = 1'b1;
      mc_oe = 1'b1;
   endtask

   function automatic logic [4:0] all_bufdir();
      return {bufdir_aux, bufdir_cs, bufdir_miso, bufdir_clock, bufdir_mosi};
   endfunction

   function automatic logic [4:0] all_bufod();
      return {bufod_aux, bufod_cs, bufod_miso, bufod_clock, bufod_mosi};
   endfunction

   task automatic test_reset();
      logic [15:0] rd;
      rst_n = 1'b0;
      repeat (3) @(negedge clock);
      total_cnt++;
      if (all_bufdir() !== 5'b0) $display("FAIL rst_bufdir got=%b want=00000", all_bufdir());
      else pass_cnt++;
      total_cnt++;
      if (all_bufod() !== 5'b0) $display("FAIL rst_bufod got=%b want=00000", all_bufod());
      else pass_cnt++;
      total_cnt++;
      if ({lat_oe, lat} !== 9'h000) $display("FAIL rst_lat got=%h want=000", {lat_oe, lat});
      else pass_cnt++;
      total_cnt++;
      if ({irq0, irq1} !== 2'b00) $display("FAIL rst_irq got=%b want=00", {irq0, irq1});
      else pass_cnt++;
      total_cnt++;
      if ({sram_clock, sram0_cs, sram1_cs} !== 3'b011)
         $display("FAIL rst_sram got=%b want=011", {sram_clock, sram0_cs, sram1_cs});
      else pass_cnt++;
      rst_n = 1'b1;
      repeat (3) @(negedge clock);
      bus_read(6'h00, rd);
      total_cnt++;
      if (rd !== 16'hB9A1) $display("FAIL read_id got=%h want=b9a1", rd);
      else pass_cnt++;
      bus_read(6'h03, rd);
      total_cnt++;
      if (rd !== 16'h0000) $display("FAIL read_out_rst got=%h want=0000", rd);
      else pass_cnt++;
      bus_read(6'h05, rd);
      total_cnt++;
      if (rd !== 16'h0000) $display("FAIL read_lat_rst got=%h want=0000", rd);
      else pass_cnt++;
      total_cnt++;
      if (all_bufdir() !== 5'b0) $display("FAIL post_rst_bufdir got=%b want=00000", all_bufdir());
      else pass_cnt++;
   endtask

   task automatic test_unmapped();
      logic [15:0] rd;
      bus_write(6'h20, 16'hFFFF);
      bus_read(6'h20, rd);
      total_cnt++;
      if (rd !== 16'h0000) $display("FAIL unmapped_read got=%h want=0000", rd);
      else pass_cnt++;
      bus_read(6'h01, rd);
      total_cnt++;
      if (rd !== 16'h0000) $display("FAIL unmapped_side_effect got=%h want=0000", rd);
      else pass_cnt++;
   endtask

   task automatic test_pushpull();
      logic [15:0] rd;
      bus_write(6'h01, 16'h0010);
      bus_write(6'h03, 16'h0010);
      total_cnt++;
      if (bufdir_aux !== 1'b1) $display("FAIL pp_bufdir_aux got=%b want=1", bufdir_aux);
      else pass_cnt++;
      total_cnt++;
      if (bufio_aux !== 1'b1) $display("FAIL pp_bufio_aux_hi got=%b want=1", bufio_aux);
      else pass_cnt++;
      total_cnt++;
      if (all_bufdir() !== 5'b10000) $display("FAIL pp_bufdir_all got=%b want=10000", all_bufdir());
      else pass_cnt++;
      bus_read(6'h01, rd);
      total_cnt++;
      if (rd !== 16'h0010) $display("FAIL pp_dir_readback got=%h want=0010", rd);
      else pass_cnt++;
      bus_write(6'h03, 16'h0000);
      total_cnt++;
      if (bufio_aux !== 1'b0) $display("FAIL pp_bufio_aux_lo got=%b want=0", bufio_aux);
      else pass_cnt++;
      total_cnt++;
      if (bufod_aux !== 1'b0) $display("FAIL pp_bufod_aux got=%b want=0", bufod_aux);
      else pass_cnt++;
   endtask

   task automatic test_opendrain();
      logic [15:0] rd;
      bus_write(6'h01, 16'h0010);
      bus_write(6'h02, 16'h0010);
      bus_write(6'h03, 16'h0010);
      total_cnt++;
      if (bufdir_aux !== 1'b0) $display("FAIL od_bufdir_rel got=%b want=0", bufdir_aux);
      else pass_cnt++;
      total_cnt++;
      if (bufod_aux !== 1'b1) $display("FAIL od_bufod_aux got=%b want=1", bufod_aux);
      else pass_cnt++;
      // Released line: an outside driver must be able to set either level.
      tb_aux_en  = 1'b1;
      tb_aux_val = 1'b0;
      repeat (4) @(negedge clock);
      bus_read(6'h04, rd);
      total_cnt++;
      if ((rd & 16'h0010) !== 16'h0000) $display("FAIL od_release_lo got=%h want=0000", rd & 16'h0010);
      else pass_cnt++;
      tb_aux_val = 1'b1;
      repeat (4) @(negedge clock);
      bus_read(6'h04, rd);
      total_cnt++;
      if ((rd & 16'h0010) !== 16'h0010) $display("FAIL od_release_hi got=%h want=0010", rd & 16'h0010);
      else pass_cnt++;
      tb_aux_en = 1'b0;
      bus_write(6'h03, 16'h0000);
      total_cnt++;
      if (bufdir_aux !== 1'b1) $display("FAIL od_bufdir_drive got=%b want=1", bufdir_aux);
      else pass_cnt++;
      total_cnt++;
      if (bufio_aux !== 1'b0) $display("FAIL od_bufio_low got=%b want=0", bufio_aux);
      else pass_cnt++;
      bus_write(6'h02, 16'h0000);
      bus_write(6'h01, 16'h0000);
   endtask

   task automatic test_irq();
      logic [15:0] rd;
      tb_miso_en  = 1'b1;
      tb_miso_val = 1'b0;
      bus_write(6'h06, 16'h0004);
      repeat (4) @(negedge clock);
      bus_write(6'h07, 16'h001F);
      repeat (2) @(negedge clock);
      total_cnt++;
      if (irq0 !== 1'b0) $display("FAIL irq_idle got=%b want=0", irq0);
      else pass_cnt++;
      bus_read(6'h04, rd);
      total_cnt++;
      if ((rd & 16'h0004) !== 16'h0000) $display("FAIL in_miso_lo got=%h want=0000", rd & 16'h0004);
      else pass_cnt++;
      @(negedge clock);
      tb_miso_val = 1'b1;
      repeat (3) @(negedge clock);
      bus_read(6'h04, rd);
      total_cnt++;
      if ((rd & 16'h0004) !== 16'h0004) $display("FAIL in_miso_hi got=%h want=0004", rd & 16'h0004);
      else pass_cnt++;
      repeat (3) @(negedge clock);
      total_cnt++;
      if (irq0 !== 1'b1) $display("FAIL irq0_set got=%b want=1", irq0);
      else pass_cnt++;
      bus_read(6'h07, rd);
      total_cnt++;
      if ((rd & 16'h0004) !== 16'h0004) $display("FAIL irqstat_set got=%h want=0004", rd & 16'h0004);
      else pass_cnt++;
      // Writing 0 leaves the pending bit alone.
      bus_write(6'h07, 16'h0000);
      total_cnt++;
      if (irq0 !== 1'b1) $display("FAIL irq0_w0_keep got=%b want=1", irq0);
      else pass_cnt++;
      bus_write(6'h07, 16'h0004);
      @(negedge clock);
      total_cnt++;
      if (irq0 !== 1'b0) $display("FAIL irq0_clear got=%b want=0", irq0);
      else pass_cnt++;
      bus_read(6'h07, rd);
      total_cnt++;
      if ((rd & 16'h0004) !== 16'h0000) $display("FAIL irqstat_clear got=%h want=0000", rd & 16'h0004);
      else pass_cnt++;
      tb_miso_en = 1'b0;
      bus_write(6'h06, 16'h0000);
   endtask

   task automatic test_lat_swirq();
      logic [15:0] rd;
      bus_write(6'h05, 16'h01A5);
      total_cnt++;
      if (lat !== 8'hA5) $display("FAIL lat_value got=%h want=a5", lat);
      else pass_cnt++;
      total_cnt++;
      if (lat_oe !== 1'b1) $display("FAIL lat_oe got=%b want=1", lat_oe);
      else pass_cnt++;
      bus_read(6'h05, rd);
      total_cnt++;
      if (rd !== 16'h01A5) $display("FAIL lat_readback got=%h want=01a5", rd);
      else pass_cnt++;
      bus_write(6'h08, 16'h0001);
      total_cnt++;
      if (irq1 !== 1'b1) $display("FAIL swirq_irq1 got=%b want=1", irq1);
      else pass_cnt++;
   endtask

   task automatic test_reset_midwrite();
      logic [15:0] rd;
      @(negedge clock);
      mc_add     = 6'h01;
      tb_data    = 16'h001F;
      tb_data_en = 1'b1;
      mc_ce      = 1'b0;
      mc_we      = 1'b0;
      repeat (4) @(negedge clock);
      rst_n = 1'b0;
      repeat (2) @(negedge clock);
      mc_we      = 1'b1;
      mc_ce      = 1'b1;
      tb_data_en = 1'b0;
      repeat (2) @(negedge clock);
      total_cnt++;
      if ({lat_oe, lat, irq0, irq1} !== 11'h000)
         $display("FAIL midrst_outputs got=%h want=000", {lat_oe, lat, irq0, irq1});
      else pass_cnt++;
      rst_n = 1'b1;
      repeat (6) @(negedge clock);
      bus_read(6'h01, rd);
      total_cnt++;
      if (rd !== 16'h0000) $display("FAIL midrst_dir got=%h want=0000", rd);
      else pass_cnt++;
      total_cnt++;
      if (all_bufdir() !== 5'b0) $display("FAIL midrst_bufdir got=%b want=00000", all_bufdir());
      else pass_cnt++;
      total_cnt++;
      if ({lat_oe, lat, irq1} !== 10'h000)
         $display("FAIL midrst_post_outputs got=%h want=000", {lat_oe, lat, irq1});
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt    = 0;
      total_cnt   = 0;
      rst_n       = 1'b0;
      mc_oe       = 1'b1;
      mc_ce       = 1'b1;
      mc_we       = 1'b1;
      mc_add      = 6'h00;
      tb_data     = 16'h0000;
      tb_data_en  = 1'b0;
      tb_miso_en  = 1'b0;
      tb_miso_val = 1'b0;
      tb_aux_en   = 1'b0;
      tb_aux_val  = 1'b0;
      test_reset();
      test_unmapped();
      test_pushpull();
      test_opendrain();
      test_irq();
      test_lat_swirq();
      test_reset_midwrite();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
